// File: rtl/fifo512_9_ctrl_pkg.sv
// Shared sizing for the 512x9 FIFO controller and its storage.
package fifo512_pkg;

  localparam int unsigned FIFO_DEPTH = 512;
  localparam int unsigned FIFO_AW    = 9;
  localparam int unsigned FIFO_DW    = 9;
  localparam int unsigned FIFO_CW    = 10;

endpackage

// File: rtl/fifo512_9_ctrl_if.sv
// Producer/consumer-side bus of the 512x9 FIFO controller.
// Watermark signals exist only when FIFO_WATERMARK_EN is defined.
interface fifo512_9_ctrl_if;
  import fifo512_pkg::*;

  logic               flush;
  logic               wr_en;
  logic [FIFO_DW-1:0] din;
  logic               rd_en;
  logic [FIFO_DW-1:0] dout;
  logic               dout_valid;
  logic               empty;
  logic               full;
  logic [FIFO_CW-1:0] level;
  logic               overflow_err;
  logic               underflow_err;
`ifdef FIFO_WATERMARK_EN
  logic               almost_full;
  logic               almost_empty;
`endif

  modport master (
    output flush, wr_en, din, rd_en,
    input  dout, dout_valid, empty, full, level, overflow_err, underflow_err
`ifdef FIFO_WATERMARK_EN
    , input almost_full, almost_empty
`endif
  );

  modport slave (
    input  flush, wr_en, din, rd_en,
    output dout, dout_valid, empty, full, level, overflow_err, underflow_err
`ifdef FIFO_WATERMARK_EN
    , output almost_full, almost_empty
`endif
  );

endinterface

// File: rtl/fifo512_9_ctrl_ram.sv
// 512x9 dual-port block RAM: write port A, registered read port B.
module dualport512_9
  import fifo512_pkg::*;
(
  input  logic               clk_a,
  input  logic               we_a,
  input  logic [FIFO_AW-1:0] addr_a,
  input  logic [FIFO_DW-1:0] din_a,
  input  logic               clk_b,
  input  logic               re_b,
  input  logic [FIFO_AW-1:0] addr_b,
  output logic [FIFO_DW-1:0] dout_b
);

  logic [FIFO_DW-1:0] mem_q [FIFO_DEPTH];
  logic [FIFO_DW-1:0] dout_b_q;

  always_ff @(posedge clk_a) begin
    if (we_a) mem_q[addr_a] <= din_a;
  end

  // Output register is left unreset so it maps onto the RAM's own output latch.
  always_ff @(posedge clk_b) begin
    if (re_b) dout_b_q <= mem_q[addr_b];
  end

  assign dout_b = dout_b_q;

endmodule

// File: rtl/fifo512_9_ctrl.sv
// Single-clock 512x9 FIFO controller: pointers, level, flags, flush, sticky errors.
// Define FIFO_WATERMARK_EN to add registered almost_full/almost_empty outputs.
module fifo512_9_ctrl
  import fifo512_pkg::*;
`ifdef FIFO_WATERMARK_EN
#(
  parameter int unsigned AFULL_THRESH  = 480,
  parameter int unsigned AEMPTY_THRESH = 32
)
`endif
(
  input  logic             clk,
  input  logic             reset_n,
  fifo512_9_ctrl_if.slave  bus
);

  logic [FIFO_CW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_CW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_CW-1:0] level_q,  level_d;
  logic               empty_q,  empty_d;
  logic               full_q,   full_d;
  logic               dout_valid_q, dout_valid_d;
  logic               ovf_q,    ovf_d;
  logic               udf_q,    udf_d;
  logic               push_acc_c;
  logic               pop_acc_c;
  logic [FIFO_DW-1:0] ram_dout;

  // Flush blocks both ports outright, so no error flag can be raised in that cycle.
  assign push_acc_c = bus.wr_en && !full_q  && !bus.flush;
  assign pop_acc_c  = bus.rd_en && !empty_q && !bus.flush;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    ovf_d        = ovf_q;
    udf_d        = udf_q;
    dout_valid_d = 1'b0;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end else begin
      if (push_acc_c) wr_ptr_d = wr_ptr_q + FIFO_CW'(1);
      if (pop_acc_c)  rd_ptr_d = rd_ptr_q + FIFO_CW'(1);
      if (bus.wr_en && full_q)  ovf_d = 1'b1;
      if (bus.rd_en && empty_q) udf_d = 1'b1;
      dout_valid_d = pop_acc_c;
    end
    // The wrap bit makes 512 distinguishable from 0 in the modulo difference.
    level_d = wr_ptr_d - rd_ptr_d;
    empty_d = (level_d == '0);
    full_d  = (level_d == FIFO_CW'(FIFO_DEPTH));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      empty_q      <= 1'b1;
      full_q       <= 1'b0;
      dout_valid_q <= 1'b0;
      ovf_q        <= 1'b0;
      udf_q        <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      empty_q      <= empty_d;
      full_q       <= full_d;
      dout_valid_q <= dout_valid_d;
      ovf_q        <= ovf_d;
      udf_q        <= udf_d;
    end
  end

`ifdef FIFO_WATERMARK_EN
  logic afull_q, afull_d;
  logic aempty_q, aempty_d;

  always_comb begin
    afull_d  = (level_d >= FIFO_CW'(AFULL_THRESH));
    aempty_d = (level_d <= FIFO_CW'(AEMPTY_THRESH));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
    end else begin
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
    end
  end

  assign bus.almost_full  = afull_q;
  assign bus.almost_empty = aempty_q;
`endif

  dualport512_9 u_ram (
    .clk_a  (clk),
    .we_a   (push_acc_c),
    .addr_a (wr_ptr_q[FIFO_AW-1:0]),
    .din_a  (bus.din),
    .clk_b  (clk),
    .re_b   (pop_acc_c),
    .addr_b (rd_ptr_q[FIFO_AW-1:0]),
    .dout_b (ram_dout)
  );

  assign bus.dout          = ram_dout;
  assign bus.dout_valid    = dout_valid_q;
  assign bus.empty         = empty_q;
  assign bus.full          = full_q;
  assign bus.level         = level_q;
  assign bus.overflow_err  = ovf_q;
  assign bus.underflow_err = udf_q;

endmodule

// File: tb/tb_fifo512_9_ctrl.sv
// Directed bench for fifo512_9_ctrl with a queue model and a pop-data scoreboard.
module tb_fifo512_9_ctrl;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  logic [8:0] mq[$];
  logic [8:0] sb[$];
  logic       m_ovf, m_udf, exp_dv;

  always #5 clk = ~clk;

  fifo512_9_ctrl_if bus();

  fifo512_9_ctrl dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    int sz;
    sz = mq.size();
    check("level",         32'(bus.level), 32'(sz));
    check("empty",         32'(bus.empty), 32'(sz == 0));
    check("full",          32'(bus.full),  32'(sz == 512));
    check("overflow_err",  32'(bus.overflow_err),  32'(m_ovf));
    check("underflow_err", 32'(bus.underflow_err), 32'(m_udf));
    check("dout_valid",    32'(bus.dout_valid),    32'(exp_dv));
`ifdef FIFO_WATERMARK_EN
    check("almost_full",   32'(bus.almost_full),  32'(sz >= 480));
    check("almost_empty",  32'(bus.almost_empty), 32'(sz <= 32));
`endif
    if (exp_dv) begin
      if (sb.size() == 0) check("scoreboard_underrun", 32'(1), 32'(0));
      else                check("dout", 32'(bus.dout), 32'(sb.pop_front()));
    end
  endtask

  // One clock of stimulus; the model predicts acceptance and errors.
  task automatic step(input logic wr, input logic [8:0] d, input logic rd, input logic fl);
    int sz;
    @(negedge clk);
    bus.wr_en = wr;
    bus.din   = d;
    bus.rd_en = rd;
    bus.flush = fl;
    sz = mq.size();
    if (fl) begin
      mq.delete();
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
      exp_dv = 1'b0;
    end else begin
      if (wr && sz == 512) m_ovf = 1'b1;
      if (rd && sz == 0)   m_udf = 1'b1;
      exp_dv = rd && (sz > 0);
      if (exp_dv) sb.push_back(mq.pop_front());
      if (wr && sz < 512) mq.push_back(d);
    end
    @(posedge clk);
    #1;
    check_state();
  endtask

  task automatic model_reset();
    mq.delete();
    sb.delete();
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
    exp_dv = 1'b0;
  endtask

  initial begin
    reset_n   = 1'b0;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.flush = 1'b0;
    bus.din   = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_state();
    @(negedge clk);
    reset_n = 1'b1;

    // Three pushes then three back-to-back pops
    step(1'b1, 9'h1A5, 1'b0, 1'b0);
    step(1'b1, 9'h0FF, 1'b0, 1'b0);
    step(1'b1, 9'h100, 1'b0, 1'b0);
    check("t1_level3", 32'(bus.level), 32'd3);
    repeat (3) step(1'b0, 9'h0, 1'b1, 1'b0);
    step(1'b0, 9'h0, 1'b0, 1'b0);
    check("t1_empty", 32'(bus.empty), 32'd1);

    // Fill to full, drop pushes while full, then drain in order
    for (int i = 0; i < 512; i++) step(1'b1, 9'(i), 1'b0, 1'b0);
    check("t2_full", 32'(bus.full), 32'd1);
    step(1'b1, 9'h055, 1'b0, 1'b0);
    check("t2_ovf", 32'(bus.overflow_err), 32'd1);
    step(1'b1, 9'h077, 1'b1, 1'b0);
    for (int i = 0; i < 511; i++) step(1'b0, 9'h0, 1'b1, 1'b0);
    step(1'b0, 9'h0, 1'b0, 1'b0);

    // Pop on empty with simultaneous push
    step(1'b1, 9'h033, 1'b1, 1'b0);
    check("t3_udf", 32'(bus.underflow_err), 32'd1);
    step(1'b0, 9'h0, 1'b0, 1'b0);
    check("t3_level1", 32'(bus.level), 32'd1);

    // Level held at 100 with concurrent push/pop across pointer wrap
    for (int i = 0; i < 99; i++) step(1'b1, 9'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 1000; i++) step(1'b1, 9'($urandom), 1'b1, 1'b0);
    check("t4_level100", 32'(bus.level), 32'd100);

    // Flush at level 200 with both errors set and both requests high
    for (int i = 0; i < 100; i++) step(1'b1, 9'($urandom), 1'b0, 1'b0);
    step(1'b1, 9'h1FF, 1'b1, 1'b1);
    check("t5_level0", 32'(bus.level), 32'd0);
    check("t5_errs",   32'({bus.overflow_err, bus.underflow_err}), 32'd0);
    check("t5_dv",     32'(bus.dout_valid), 32'd0);

`ifdef FIFO_WATERMARK_EN
    for (int i = 0; i < 479; i++) step(1'b1, 9'(i), 1'b0, 1'b0);
    check("t6_afull_479", 32'(bus.almost_full), 32'd0);
    step(1'b1, 9'h1E0, 1'b0, 1'b0);
    check("t6_afull_480", 32'(bus.almost_full), 32'd1);
    for (int i = 0; i < 447; i++) step(1'b0, 9'h0, 1'b1, 1'b0);
    check("t6_aempty_33", 32'(bus.almost_empty), 32'd0);
    step(1'b0, 9'h0, 1'b1, 1'b0);
    check("t6_aempty_32", 32'(bus.almost_empty), 32'd1);
`endif

    // Async reset in the middle of a push/pop burst
    for (int i = 0; i < 20; i++) step(1'b1, 9'(i + 7), (i > 4), 1'b0);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_state();
    @(negedge clk);
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b1, 9'h0AA, 1'b0, 1'b0);
    step(1'b0, 9'h0, 1'b1, 1'b0);
    step(1'b0, 9'h0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
